mc_control_fsm: RTL and testbench

- Multicycle control unit for the RV32I core; it drives the ALU's 3-bit control input and consumes the ALU's Zero flag.
- A Moore FSM sequences fetch, decode, execute, memory and writeback for lw, sw, R-type, I-type ALU, beq and jal.
- It produces all datapath select and write-enable signals.
- It decodes op/funct3/funct7b5 into ALUControl using the datapath ALU encoding.

---
 rtl/mc_control_fsm.sv | 200 ++++++++++++++++++++
 tb/tb_mc_control_fsm.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mc_control_fsm.sv
// mc_control_fsm -- multicycle control unit for an RV32I core.
//
// A Moore FSM steps each instruction through FETCH / DECODE / execute /
// memory / writeback states and decodes the opcode fields into the
// datapath selects, write enables, immediate type and ALU control.
//
// Ports
//   clk         core clock, rising edge
//   reset_n     asynchronous active-low reset (state -> FETCH, writes off)
//   op          Instr[6:0]
//   funct3      Instr[14:12]
//   funct7b5    Instr[30]
//   Zero        ALU zero flag, consumed in the BEQ cycle
//   PCWrite     PC enable = PCUpdate | (Branch & Zero)
//   AdrSrc      memory address: 0=PC, 1=ALUOut
//   MemWrite    data memory write enable
//   IRWrite     IR/OldPC enable
//   RegWrite    register file write enable
//   ResultSrc   00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA     00=PC, 01=OldPC, 10=RegA
//   ALUSrcB     00=RegB, 01=ImmExt, 10=constant 4
//   ImmSrc      00=I, 01=S, 10=B, 11=J
//   ALUControl  000 add, 001 sub, 010 and, 011 or, 101 slt
//   InstrDone   high in the last cycle of lw/sw/R/I/beq/jal
//   IllegalOp   high in DECODE for an unsupported opcode
module mc_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       InstrDone,
  output logic       IllegalOp
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL
  } state_e;

  state_e state_q, state_d;

  // Raw per-state controls, before reset gating and ALU decode.
  logic       pc_update, branch, mem_write_raw, ir_write_raw, reg_write_raw;
  logic [1:0] alu_op;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_FETCH;
    else          state_q <= state_d;
  end

  // NOTE: every signal driven here gets a default first; a path that
  // skipped one would infer a latch.
  always_comb begin
    state_d       = S_FETCH;
    pc_update     = 1'b0;
    branch        = 1'b0;
    mem_write_raw = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    alu_op        = 2'b00;
    AdrSrc        = 1'b0;
    ResultSrc     = 2'b00;
    ALUSrcA       = 2'b00;
    ALUSrcB       = 2'b00;
    InstrDone     = 1'b0;
    IllegalOp     = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        state_d      = S_DECODE;
        ir_write_raw = 1'b1;
        pc_update    = 1'b1;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
      end
      S_DECODE: begin
        // Branch target is precomputed into ALUOut here.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        unique case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default: begin
            state_d   = S_FETCH;
            IllegalOp = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        state_d = S_MEMWB;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc     = 2'b01;
        reg_write_raw = 1'b1;
        InstrDone     = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc        = 1'b1;
        mem_write_raw = 1'b1;
        InstrDone     = 1'b1;
      end
      S_EXECR: begin
        state_d = S_ALUWB;
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        state_d = S_ALUWB;
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: begin
        reg_write_raw = 1'b1;
        InstrDone     = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA   = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        InstrDone = 1'b1;
      end
      S_JAL: begin
        // Old PC + 4 becomes the link value written back in ALUWB.
        state_d   = S_ALUWB;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write enables are masked by reset_n directly so an instruction cut off
  // by reset issues no write even before the state register reloads.
  assign PCWrite  = reset_n & (pc_update | (branch & Zero));
  assign IRWrite  = reset_n & ir_write_raw;
  assign RegWrite = reset_n & reg_write_raw;
  assign MemWrite = reset_n & mem_write_raw;

  always_comb begin
    unique case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    unique case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        unique case (funct3)
          // Only R-type (op[5]=1) uses funct7b5 to select sub; addi ignores it.
          3'b000:  ALUControl = (funct7b5 & op[5]) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm -- table-driven bench for mc_control_fsm.
// Each table row is one clock cycle: the inputs held during that cycle and
// the full output vector expected for the state the FSM should be in.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       InstrDone, IllegalOp;

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .reset_n(reset_n), .op(op), .funct3(funct3),
    .funct7b5(funct7b5), .Zero(Zero), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .InstrDone(InstrDone),
    .IllegalOp(IllegalOp)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Packed order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc
  //               ALUSrcA ALUSrcB ImmSrc ALUControl InstrDone IllegalOp
  function automatic logic [17:0] outs(input logic pcw, adr, mw, irw, rw,
                                       input logic [1:0] rs, a, b, imm,
                                       input logic [2:0] alu,
                                       input logic done, ill);
    return {pcw, adr, mw, irw, rw, rs, a, b, imm, alu, done, ill};
  endfunction

  function automatic logic [17:0] actual();
    return {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
            ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, IllegalOp};
  endfunction

  // Expected outputs of each state, written out from the control table.
  function automatic logic [17:0] e_fetch(input logic [1:0] imm);
    return outs(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_decode(input logic [1:0] imm, input logic ill);
    return outs(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, ill);
  endfunction
  function automatic logic [17:0] e_memadr(input logic [1:0] imm);
    return outs(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0, 0);
  endfunction
  function automatic logic [17:0] e_execr(input logic [2:0] alu);
    return outs(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b00, alu, 0, 0);
  endfunction
  function automatic logic [17:0] e_execi(input logic [2:0] alu);
    return outs(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, alu, 0, 0);
  endfunction
  function automatic logic [17:0] e_aluwb(input logic [1:0] imm);
    return outs(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
  endfunction
  function automatic logic [17:0] e_beq(input logic z);
    return outs(z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001, 1, 0);
  endfunction

  localparam logic [17:0] E_MEMREAD  = 18'(outs(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 0, 0));
  localparam logic [17:0] E_MEMWB    = 18'(outs(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 1, 0));
  localparam logic [17:0] E_MEMWRITE = 18'(outs(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1, 0));
  localparam logic [17:0] E_JAL      = 18'(outs(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000, 0, 0));

  task automatic add(input string name, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic [17:0] exp);
    vec_t v;
    v.name = name; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %05h expected %05h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Hold inputs for one cycle, compare on the falling edge, step past the
  // next rising edge.
  task automatic run_vec(input vec_t v);
    op = v.op; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z;
    @(negedge clk);
    check(v.name, actual(), v.exp);
    @(posedge clk);
    #1;
  endtask

  // R-type funct3/funct7b5 variants and the ALUControl each must yield.
  logic [2:0] r_f3  [6] = '{3'b000, 3'b000, 3'b010, 3'b110, 3'b111, 3'b100};
  logic       r_f7  [6] = '{1'b1,   1'b0,   1'b0,   1'b0,   1'b0,   1'b0};
  logic [2:0] r_alu [6] = '{3'b001, 3'b000, 3'b101, 3'b011, 3'b010, 3'b000};

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // lw: 5 cycles; Zero held high to show it cannot leak into PCWrite.
    add("lw_fetch",   OP_LW, 3'b010, 0, 1, e_fetch(2'b00));
    add("lw_decode",  OP_LW, 3'b010, 0, 1, e_decode(2'b00, 0));
    add("lw_memadr",  OP_LW, 3'b010, 0, 1, e_memadr(2'b00));
    add("lw_memread", OP_LW, 3'b010, 0, 1, E_MEMREAD);
    add("lw_memwb",   OP_LW, 3'b010, 0, 1, E_MEMWB);
    // sw: 4 cycles
    add("sw_fetch",    OP_SW, 3'b010, 0, 0, e_fetch(2'b01));
    add("sw_decode",   OP_SW, 3'b010, 0, 0, e_decode(2'b01, 0));
    add("sw_memadr",   OP_SW, 3'b010, 0, 0, e_memadr(2'b01));
    add("sw_memwrite", OP_SW, 3'b010, 0, 0, E_MEMWRITE);
    // R-type variants
    for (int i = 0; i < 6; i++) begin
      add($sformatf("r%0d_fetch", i),  OP_R, r_f3[i], r_f7[i], 0, e_fetch(2'b00));
      add($sformatf("r%0d_decode", i), OP_R, r_f3[i], r_f7[i], 0, e_decode(2'b00, 0));
      add($sformatf("r%0d_execr", i),  OP_R, r_f3[i], r_f7[i], 0, e_execr(r_alu[i]));
      add($sformatf("r%0d_aluwb", i),  OP_R, r_f3[i], r_f7[i], 0, e_aluwb(2'b00));
    end
    // addi with funct7b5=1 stays an add; slti gives slt
    add("addi_fetch",  OP_I, 3'b000, 1, 0, e_fetch(2'b00));
    add("addi_decode", OP_I, 3'b000, 1, 0, e_decode(2'b00, 0));
    add("addi_execi",  OP_I, 3'b000, 1, 0, e_execi(3'b000));
    add("addi_aluwb",  OP_I, 3'b000, 1, 0, e_aluwb(2'b00));
    add("slti_fetch",  OP_I, 3'b010, 0, 0, e_fetch(2'b00));
    add("slti_decode", OP_I, 3'b010, 0, 0, e_decode(2'b00, 0));
    add("slti_execi",  OP_I, 3'b010, 0, 0, e_execi(3'b101));
    add("slti_aluwb",  OP_I, 3'b010, 0, 0, e_aluwb(2'b00));
    // beq taken / not taken: 3 cycles each
    add("beqt_fetch",  OP_BEQ, 3'b000, 0, 1, e_fetch(2'b10));
    add("beqt_decode", OP_BEQ, 3'b000, 0, 1, e_decode(2'b10, 0));
    add("beqt_beq",    OP_BEQ, 3'b000, 0, 1, e_beq(1'b1));
    add("beqn_fetch",  OP_BEQ, 3'b000, 0, 0, e_fetch(2'b10));
    add("beqn_decode", OP_BEQ, 3'b000, 0, 0, e_decode(2'b10, 0));
    add("beqn_beq",    OP_BEQ, 3'b000, 0, 0, e_beq(1'b0));
    // jal: FETCH, DECODE, JAL, ALUWB
    add("jal_fetch",  OP_JAL, 3'b000, 0, 0, e_fetch(2'b11));
    add("jal_decode", OP_JAL, 3'b000, 0, 0, e_decode(2'b11, 0));
    add("jal_jal",    OP_JAL, 3'b000, 0, 0, E_JAL);
    add("jal_aluwb",  OP_JAL, 3'b000, 0, 0, e_aluwb(2'b11));
    // illegal op: 2 cycles, then a fresh FETCH
    add("bad_fetch",  OP_BAD, 3'b000, 0, 1, e_fetch(2'b00));
    add("bad_decode", OP_BAD, 3'b000, 0, 1, e_decode(2'b00, 1));
    add("post_fetch", OP_LW,  3'b000, 0, 0, e_fetch(2'b00));

    // Reset held: FETCH selects, all write enables off.
    reset_n = 1'b0; op = OP_LW; funct3 = 3'b000; funct7b5 = 1'b0; Zero = 1'b1;
    #2;
    check("rst_async", actual(), outs(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
    @(posedge clk); #1;
    check("rst_held", actual(), outs(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000, 0, 0));
    reset_n = 1'b1;

    foreach (tbl[i]) run_vec(tbl[i]);

    // Reset mid-MEMWRITE: we are now in DECODE of the trailing lw FETCH;
    // restart cleanly with an sw.
    reset_n = 1'b0; #1;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int i = 5; i < 8; i++) run_vec(tbl[i]);  // sw FETCH, DECODE, MEMADR
    op = OP_SW; funct3 = 3'b010; funct7b5 = 1'b0; Zero = 1'b0;
    #1;
    check("mw_before_rst", actual(), E_MEMWRITE);
    reset_n = 1'b0;
    #1;
    check("mw_rst_async", actual(), outs(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
    @(posedge clk); #1;
    check("mw_rst_held", actual(), outs(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000, 0, 0));
    reset_n = 1'b1;
    op = OP_LW;
    #1;
    check("rel_fetch", actual(), e_fetch(2'b00));
    @(posedge clk); #1;
    check("rel_decode", actual(), e_decode(2'b00, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
